// File: rtl/occupancy_bin2bcd_pkg.sv
// Shared types and constants for the occupancy binary-to-BCD converter.
// Holds the FSM state encoding, BCD digit width and the parameter legality check.
package occupancy_bin2bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP   = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned BCD_W = 4;

    // Requires 10**digits > 2**width-1, plus at least three digits to feed bcd2..bcd0.
    function automatic bit digits_legal(input int unsigned width, input int unsigned digits);
        longint unsigned pow10;
        longint unsigned max_bin;
        pow10 = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            pow10 = pow10 * 64'd10;
        end
        max_bin = (64'd1 << width) - 64'd1;
        return (digits >= 3) && (width >= 1) && (width <= 32) && (pow10 > max_bin);
    endfunction

endpackage

// File: rtl/occupancy_bin2bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj
    import occupancy_bin2bcd_pkg::*;
(
    input  logic [BCD_W-1:0] i_digit,
    output logic [BCD_W-1:0] o_digit
);

    always_comb begin
        o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;
    end

endmodule

// File: rtl/occupancy_bin2bcd.sv
// Iterative shift-add-3 converter: one input bit per clock, start/done handshake.
// Converts the occupancy count into hundreds/tens/ones digits for the display driver.
module occupancy_bin2bcd
    import occupancy_bin2bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic             ready,
    output logic             done_tick,
    output logic [3:0]       bcd2,
    output logic [3:0]       bcd1,
    output logic [3:0]       bcd0
);

    localparam int unsigned NW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned BW = DIGITS * BCD_W;

    generate
        if (!digits_legal(WIDTH, DIGITS)) begin : g_param_check
            $error("occupancy_bin2bcd: DIGITS too small for WIDTH");
        end
    endgenerate

    state_t                 r_state;
    logic [NW-1:0]          r_n;
    logic [WIDTH-1:0]       r_bin_sr;
    logic [BW-1:0]          r_work;
    logic [BW-1:0]          r_out;
    logic                   r_done_tick;
    logic [BW-1:0]          w_adj;
    logic [BW+WIDTH-1:0]    w_shift;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .i_digit (r_work[g*BCD_W +: BCD_W]),
                .o_digit (w_adj[g*BCD_W +: BCD_W])
            );
        end
    endgenerate

    assign w_shift = {w_adj, r_bin_sr} << 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_n         <= '0;
            r_bin_sr    <= '0;
            r_work      <= '0;
            r_out       <= '0;
            r_done_tick <= 1'b0;
        end else begin
            r_done_tick <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bin_sr <= bin;
                        r_work   <= '0;
                        r_n      <= NW'(WIDTH - 1);
                        r_state  <= ST_OP;
                    end
                end
                ST_OP: begin
                    {r_work, r_bin_sr} <= w_shift;
                    // Publish the final shift directly so DONE shows the result on entry.
                    if (r_n == '0) begin
                        r_out       <= w_shift[BW+WIDTH-1:WIDTH];
                        r_done_tick <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_n <= r_n - 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ready     = (r_state == ST_IDLE);
    assign done_tick = r_done_tick;
    assign bcd0      = r_out[0*BCD_W +: BCD_W];
    assign bcd1      = r_out[1*BCD_W +: BCD_W];
    assign bcd2      = r_out[2*BCD_W +: BCD_W];

endmodule

// File: tb/tb_occupancy_bin2bcd.sv
// Self-checking bench for occupancy_bin2bcd: vector table, exhaustive sweep and
// hand-written abort/ignore sequences, with a done_tick-driven result scoreboard.
module tb_occupancy_bin2bcd;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] bin;
    logic       ready;
    logic       done_tick;
    logic [3:0] bcd2;
    logic [3:0] bcd1;
    logic [3:0] bcd0;

    occupancy_bin2bcd #(.WIDTH(8), .DIGITS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bin       (bin),
        .ready     (ready),
        .done_tick (done_tick),
        .bcd2      (bcd2),
        .bcd1      (bcd1),
        .bcd0      (bcd0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  vin;
        logic [11:0] vexp;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          n_ticks = 0;
    int          n_accepted = 0;
    logic [11:0] sb[$];
    logic [11:0] last_result = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] bcd_of(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    // Scoreboard: every done_tick must match the oldest outstanding conversion.
    always @(posedge clk) begin
        #1;
        if (done_tick === 1'b1) begin
            n_ticks++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done_tick: got done_tick=1, expected 0 (t=%0t)", $time);
            end else begin
                check("result", {20'd0, bcd2, bcd1, bcd0}, {20'd0, sb.pop_front()});
            end
        end
    end

    // One conversion; optionally inject a second start/bin during OP cycle 3.
    task automatic convert(input logic [7:0] b, input bit inject, input logic [7:0] inj_bin);
        int  k;
        bit  seen;
        k = 0;
        while (ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ready_before_start", {31'd0, ready}, 32'd1);
        @(negedge clk);
        bin   = b;
        start = 1'b1;
        sb.push_back(bcd_of(int'(b)));
        n_accepted++;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ready_low_after_accept", {31'd0, ready}, 32'd0);
        seen = 1'b0;
        for (k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (done_tick === 1'b1) begin
                seen = 1'b1;
                break;
            end
            check("hold_until_done", {20'd0, bcd2, bcd1, bcd0}, {20'd0, last_result});
            if (inject && k == 2) begin
                start = 1'b1;
                bin   = inj_bin;
            end
            if (inject && k == 3) begin
                start = 1'b0;
            end
        end
        if (seen) begin
            check("latency", k + 1, 32'd9);
        end else begin
            check("done_timeout", 32'd0, 32'd1);
        end
        last_result = bcd_of(int'(b));
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'd0,   12'h000};
        vecs[1] = '{8'd255, 12'h255};
        vecs[2] = '{8'd99,  12'h099};
        vecs[3] = '{8'd100, 12'h100};
        vecs[4] = '{8'd9,   12'h009};
        vecs[5] = '{8'd10,  12'h010};
        vecs[6] = '{8'd199, 12'h199};
        vecs[7] = '{8'd128, 12'h128};

        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_done", {31'd0, done_tick}, 32'd0);
        check("reset_bcd", {20'd0, bcd2, bcd1, bcd0}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_ready", {31'd0, ready}, 32'd1);
        check("post_reset_bcd", {20'd0, bcd2, bcd1, bcd0}, 32'd0);

        // Table-driven vectors, including the expectation table itself against the model.
        for (int i = 0; i < 8; i++) begin
            check("table_model", {20'd0, bcd_of(int'(vecs[i].vin))}, {20'd0, vecs[i].vexp});
            convert(vecs[i].vin, 1'b0, 8'd0);
        end

        // Exhaustive sweep.
        for (int v = 0; v < 256; v++) begin
            convert(8'(v), 1'b0, 8'd0);
        end

        // Start with a different bin while busy is ignored.
        convert(8'd37, 1'b1, 8'd200);
        repeat (12) @(posedge clk);
        #1;
        check("after_ignored_start", {20'd0, bcd2, bcd1, bcd0}, 32'h037);

        // Reset during OP cycle 4 aborts without a done_tick.
        @(negedge clk);
        bin   = 8'd77;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_bcd", {20'd0, bcd2, bcd1, bcd0}, 32'd0);
        check("abort_done", {31'd0, done_tick}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        last_result = '0;
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_result", {20'd0, bcd2, bcd1, bcd0}, 32'd0);
        convert(8'd128, 1'b0, 8'd0);

        repeat (12) @(posedge clk);
        #2;
        check("scoreboard_empty", sb.size(), 32'd0);
        check("tick_per_start", n_ticks, n_accepted);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
